// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: divides clk into a pixel-rate enable and walks h/v counters.
// Once started, a frame always runs to completion before the block returns to STOPPED.
module vga_timing_ctrl #(
   parameter int DIV      = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_end,
   output logic       busy
);

   typedef enum logic [1:0] {
      STOPPED,
      RUNNING,
      DRAINING
   } state_t;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]    V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]    HS_FIRST  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]    HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]    VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   state_t        state_q, state_d;
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]    h_cnt_q, h_cnt_d;
   logic [9:0]    v_cnt_q, v_cnt_d;

   logic active;
   logic h_last;
   logic v_last;

   // Output decode straight from the registers, so no added latency.
   always_comb begin
      active    = (state_q != STOPPED);
      h_last    = (h_cnt_q == H_LAST);
      v_last    = (v_cnt_q == V_LAST);
      pix_tick  = active && (div_cnt_q == DIV_LAST);
      frame_end = pix_tick && h_last && v_last;
      hsync     = !(active && (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vsync     = !(active && (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      video_on  = active && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      pixel_x   = h_cnt_q;
      pixel_y   = v_cnt_q;
      busy      = active;
   end

   // enable on the frame_end cycle wins over stopping, keeping frames back to back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         STOPPED:  if (enable) state_d = RUNNING;
         RUNNING:  if (!enable) state_d = DRAINING;
         DRAINING: begin
            if (enable) begin
               state_d = RUNNING;
            end else if (frame_end) begin
               state_d = STOPPED;
            end
         end
         default:  state_d = STOPPED;
      endcase
   end

   always_comb begin
      div_cnt_d = div_cnt_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (state_q != STOPPED) begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
         if (pix_tick) begin
            h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
            if (h_last) begin
               v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
            end
         end
      end
      if (state_d == STOPPED) begin
         div_cnt_d = '0;
         h_cnt_d   = 10'd0;
         v_cnt_d   = 10'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= STOPPED;
         div_cnt_q <= '0;
         h_cnt_q   <= 10'd0;
         v_cnt_q   <= 10'd0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl using a shrunken 48x27 raster (DIV=4) so full frames stay short.
// Sync windows: hsync low for x 36..43, vsync low for y 22..23, active area 32x20.
module tb_vga_timing_ctrl;

   localparam int DIV      = 4;
   localparam int H_ACTIVE = 32;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 8;
   localparam int H_BP     = 4;
   localparam int V_ACTIVE = 20;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int LIMIT    = 6000;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       pix_tick;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_end;
   logic       busy;

   int checks = 0;
   int errors = 0;

   vga_timing_ctrl #(
      .DIV(DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .pix_tick(pix_tick),
      .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel_x(pixel_x),
      .pixel_y(pixel_y), .frame_end(frame_end), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst_v, input logic en_v);
      reset  = rst_v;
      enable = en_v;
   endtask

   task automatic checkStopped(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_tick"}, 32'(pix_tick), 0);
      checkOutput({tag, "_fe"}, 32'(frame_end), 0);
      checkOutput({tag, "_hsync"}, 32'(hsync), 1);
      checkOutput({tag, "_vsync"}, 32'(vsync), 1);
      checkOutput({tag, "_video"}, 32'(video_on), 0);
      checkOutput({tag, "_x"}, 32'(pixel_x), 0);
      checkOutput({tag, "_y"}, 32'(pixel_y), 0);
   endtask

   // Caller has just raised enable at a negedge while the DUT is STOPPED.
   task automatic checkStartup(input string tag);
      @(negedge clk);
      checkOutput({tag, "_busy1"}, 32'(busy), 1);
      checkOutput({tag, "_tick_c0"}, 32'(pix_tick), 0);
      @(negedge clk);
      checkOutput({tag, "_tick_c1"}, 32'(pix_tick), 0);
      @(negedge clk);
      checkOutput({tag, "_tick_c2"}, 32'(pix_tick), 0);
      @(negedge clk);
      checkOutput({tag, "_tick_c3"}, 32'(pix_tick), 1);
      checkOutput({tag, "_x_c3"}, 32'(pixel_x), 0);
      repeat (3) @(negedge clk);
      checkOutput({tag, "_tick_c6"}, 32'(pix_tick), 0);
      @(negedge clk);
      checkOutput({tag, "_tick_c7"}, 32'(pix_tick), 1);
      checkOutput({tag, "_x_c7"}, 32'(pixel_x), 1);
   endtask

   task automatic waitPixel(input int x, input int y, input string tag);
      int found = 0;
      for (int i = 0; i < LIMIT && found == 0; i++) begin
         @(negedge clk);
         if (pix_tick === 1'b1 && pixel_x == 10'(x) && pixel_y == 10'(y)) found = 1;
      end
      checkOutput(tag, 32'(found), 1);
   endtask

   initial begin
      int first_tick, last_tick, gap_bad, ticks, busy_low;
      int hs_low, hs_line0, hs_first, hs_xmax;
      int vid_on, vid_line0, vid_xmax, vid_ymax;
      int vs_low, vs_ymin, vs_ymax;
      int fe_count, fe_idx, fe_x, fe_y, found;

      applyStimulus(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      checkStopped("reset_hold");
      applyStimulus(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkStopped("idle_after_reset");

      // Full first frame observed cycle by cycle from the first RUNNING clock.
      applyStimulus(1'b0, 1'b1);
      first_tick = -1; last_tick = -1; gap_bad = 0; ticks = 0; busy_low = 0;
      hs_low = 0; hs_line0 = 0; hs_first = -1; hs_xmax = -1;
      vid_on = 0; vid_line0 = 0; vid_xmax = -1; vid_ymax = -1;
      vs_low = 0; vs_ymin = 999; vs_ymax = -1;
      fe_count = 0; fe_idx = -1; fe_x = -1; fe_y = -1;
      for (int i = 0; i < 48 * 27 * DIV; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_low++;
         if (pix_tick === 1'b1) begin
            if (first_tick < 0) first_tick = i;
            else if (i - last_tick != DIV) gap_bad++;
            last_tick = i;
            ticks++;
            if (hsync === 1'b0) begin
               hs_low++;
               if (hs_first < 0) hs_first = int'(pixel_x);
               if (int'(pixel_x) > hs_xmax) hs_xmax = int'(pixel_x);
            end
            if (video_on === 1'b1) begin
               vid_on++;
               if (int'(pixel_x) > vid_xmax) vid_xmax = int'(pixel_x);
               if (int'(pixel_y) > vid_ymax) vid_ymax = int'(pixel_y);
            end
            if (vsync === 1'b0) begin
               vs_low++;
               if (int'(pixel_y) < vs_ymin) vs_ymin = int'(pixel_y);
               if (int'(pixel_y) > vs_ymax) vs_ymax = int'(pixel_y);
            end
         end
         if (frame_end === 1'b1) begin
            fe_count++;
            fe_idx = i;
            fe_x = int'(pixel_x);
            fe_y = int'(pixel_y);
         end
         if (i == 48 * DIV - 1) begin
            hs_line0  = hs_low;
            vid_line0 = vid_on;
         end
      end
      checkOutput("first_tick_idx", 32'(first_tick), 3);
      checkOutput("tick_gap_bad", 32'(gap_bad), 0);
      checkOutput("frame_busy_low", 32'(busy_low), 0);
      checkOutput("frame_ticks", 32'(ticks), 1296);
      checkOutput("line0_hsync_ticks", 32'(hs_line0), 8);
      checkOutput("hsync_first_x", 32'(hs_first), 36);
      checkOutput("hsync_last_x", 32'(hs_xmax), 43);
      checkOutput("frame_hsync_ticks", 32'(hs_low), 216);
      checkOutput("line0_video_ticks", 32'(vid_line0), 32);
      checkOutput("frame_video_ticks", 32'(vid_on), 640);
      checkOutput("video_xmax", 32'(vid_xmax), 31);
      checkOutput("video_ymax", 32'(vid_ymax), 19);
      checkOutput("vsync_ticks", 32'(vs_low), 96);
      checkOutput("vsync_ymin", 32'(vs_ymin), 22);
      checkOutput("vsync_ymax", 32'(vs_ymax), 23);
      checkOutput("frame_end_count", 32'(fe_count), 1);
      checkOutput("frame_end_idx", 32'(fe_idx), 5183);
      checkOutput("frame_end_x", 32'(fe_x), 47);
      checkOutput("frame_end_y", 32'(fe_y), 26);
      @(negedge clk);
      checkOutput("frame2_x", 32'(pixel_x), 0);
      checkOutput("frame2_y", 32'(pixel_y), 0);
      checkOutput("frame2_busy", 32'(busy), 1);
      checkOutput("frame2_video", 32'(video_on), 1);

      // Drop enable mid-frame: the frame must still finish, then stop.
      waitPixel(10, 5, "reach_10_5");
      applyStimulus(1'b0, 1'b0);
      found = 0; ticks = 0; busy_low = 0; fe_x = -1; fe_y = -1;
      for (int i = 0; i < LIMIT && found == 0; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_low++;
         if (pix_tick === 1'b1) ticks++;
         if (frame_end === 1'b1) begin
            found = 1;
            fe_x = int'(pixel_x);
            fe_y = int'(pixel_y);
         end
      end
      checkOutput("drain_found_end", 32'(found), 1);
      checkOutput("drain_ticks", 32'(ticks), 1045);
      checkOutput("drain_busy_low", 32'(busy_low), 0);
      checkOutput("drain_end_x", 32'(fe_x), 47);
      checkOutput("drain_end_y", 32'(fe_y), 26);
      @(negedge clk);
      checkStopped("drain_stopped");
      repeat (8) @(negedge clk);
      checkStopped("drain_still_stopped");

      // Restart, then drop and re-raise enable mid-frame without disturbing timing.
      applyStimulus(1'b0, 1'b1);
      checkStartup("restart");
      waitPixel(5, 3, "reach_5_3");
      applyStimulus(1'b0, 1'b0);
      gap_bad = 0; busy_low = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_low++;
         if ((pix_tick === 1'b1) != (k % DIV == 0)) gap_bad++;
         if (k == 40) applyStimulus(1'b0, 1'b1);
      end
      checkOutput("reraise_gap_bad", 32'(gap_bad), 0);
      checkOutput("reraise_busy_low", 32'(busy_low), 0);
      checkOutput("reraise_tick", 32'(pix_tick), 1);
      checkOutput("reraise_x", 32'(pixel_x), 30);
      checkOutput("reraise_y", 32'(pixel_y), 3);

      // enable returns exactly on the frame_end cycle: must keep running.
      applyStimulus(1'b0, 1'b0);
      found = 0;
      for (int i = 0; i < LIMIT && found == 0; i++) begin
         @(negedge clk);
         if (frame_end === 1'b1) begin
            found = 1;
            applyStimulus(1'b0, 1'b1);
         end
      end
      checkOutput("fe_enable_found", 32'(found), 1);
      @(negedge clk);
      checkOutput("fe_enable_busy", 32'(busy), 1);
      checkOutput("fe_enable_video", 32'(video_on), 1);
      checkOutput("fe_enable_x", 32'(pixel_x), 0);
      checkOutput("fe_enable_y", 32'(pixel_y), 0);
      repeat (3) @(negedge clk);
      checkOutput("fe_enable_tick", 32'(pix_tick), 1);

      // Asynchronous reset between clock edges while hsync and vsync are both low.
      waitPixel(38, 22, "reach_38_22");
      checkOutput("pre_reset_hsync", 32'(hsync), 0);
      checkOutput("pre_reset_vsync", 32'(vsync), 0);
      #2;
      applyStimulus(1'b1, 1'b1);
      #1;
      checkStopped("async_reset");
      repeat (2) @(negedge clk);
      checkStopped("async_reset_hold");
      applyStimulus(1'b0, 1'b1);
      checkStartup("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
